// File: rtl/adc_trig_capture.sv
// Multi-channel ADC trigger/capture: abs-sum detector with a pre-trigger circular buffer feeding AXI-Stream records.
// Latency: 3-stage sum pipeline, then PRE_DEPTH cycles of delay; the stream never stalls (words refused by the sink are counted as dropped).
module adc_trig_capture #(
  parameter int N_CH           = 2,
  parameter int ADC_DATA_WIDTH = 14,
  parameter int PRE_DEPTH      = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [N_CH*16-1:0]     adc_dat,
  input  logic [15:0]            trigger_level,
  input  logic [15:0]            hysteresis,
  input  logic [31:0]            record_len,
  input  logic [31:0]            holdoff_len,
  input  logic                   reset_trigger,
  input  logic                   reset_max_sum,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [80+16*N_CH-1:0]  m_axis_tdata,
  output logic [15:0]            max_sum_out,
  output logic [15:0]            triggers_count,
  output logic [63:0]            first_trigged,
  output logic [31:0]            records_done,
  output logic [31:0]            dropped_count,
  output logic [1:0]             state_out,
  output logic [63:0]            cur_sample
);

  localparam int W   = ADC_DATA_WIDTH;
  localparam int TDW = 80 + 16*N_CH;
  localparam int AW  = $clog2(PRE_DEPTH);

  typedef enum logic [1:0] {WARMUP = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, HOLDOFF = 2'd3} state_t;

  state_t               state, state_n;
  logic [63:0]          sample_counter;
  logic [W-1:0]         s1_ch  [N_CH];
  logic [W-1:0]         s2_abs [N_CH];
  logic [15:0]          s2_raw [N_CH];
  logic [15:0]          s3_sum, sum_c;
  logic [63:0]          s3_stamp;
  logic [16*N_CH-1:0]   s3_raw;
  logic                 s3_live;
  logic [TDW:0]         buf_mem [PRE_DEPTH];
  logic [AW-1:0]        wp;
  logic [TDW:0]         dly_raw;
  logic [TDW-1:0]       dly_word;
  logic [15:0]          disarm;
  logic                 rearm, over;
  logic [31:0]          rem, rem_n, hold, hold_n;
  logic                 vld_n, last_n;
  logic [15:0]          trig_n;
  logic [63:0]          first_n;
  logic [31:0]          done_n;
  logic                 unused_adc_bits;

  assign unused_adc_bits = ^adc_dat;
  assign cur_sample      = sample_counter;
  assign state_out       = state;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) sample_counter <= '0;
    else          sample_counter <= sample_counter + 64'd1;
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < N_CH; k++) sum_c = sum_c + {{(16-W){1'b0}}, s2_abs[k]};
  end

  // The W-bit negation leaves the most negative code as 2^(W-1) read unsigned.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < N_CH; k++) begin
        s1_ch[k]  <= '0;
        s2_abs[k] <= '0;
        s2_raw[k] <= '0;
      end
      s3_sum   <= '0;
      s3_stamp <= '0;
      s3_raw   <= '0;
      s3_live  <= 1'b0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        s1_ch[k]  <= adc_dat[16*k+15 -: W];
        s2_abs[k] <= s1_ch[k][W-1] ? (~s1_ch[k] + 1'b1) : s1_ch[k];
        s2_raw[k] <= {{(16-W){s1_ch[k][W-1]}}, s1_ch[k]};
        s3_raw[16*k +: 16] <= s2_raw[k];
      end
      s3_sum   <= sum_c;
      s3_stamp <= sample_counter;
      s3_live  <= (state != WARMUP);
    end
  end

  // Slot at wp was written PRE_DEPTH cycles ago, so reading before overwrite yields stamp - PRE_DEPTH.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < PRE_DEPTH; i++) buf_mem[i] <= '0;
      wp <= '0;
    end else begin
      buf_mem[wp] <= {s3_live, s3_stamp, s3_sum, s3_raw};
      wp          <= wp + 1'b1;
    end
  end

  // The 16'hA1B2 marker does not fit the 80+16*N_CH output and is not carried.
  assign dly_raw  = buf_mem[wp];
  assign dly_word = dly_raw[TDW] ? dly_raw[TDW-1:0] : {dly_raw[TDW-1 -: 64], {(16+16*N_CH){1'b0}}};

  assign disarm = (trigger_level > hysteresis) ? (trigger_level - hysteresis) : 16'd0;
  assign rearm  = (s3_sum <= disarm);
  assign over   = (s3_sum > trigger_level);

  always_comb begin
    state_n = state;
    rem_n   = rem;
    hold_n  = hold;
    vld_n   = 1'b0;
    last_n  = 1'b0;
    trig_n  = triggers_count;
    first_n = first_trigged;
    done_n  = records_done;
    if (reset_trigger) begin
      state_n = ARMED;
      rem_n   = '0;
      hold_n  = '0;
      trig_n  = '0;
      first_n = '0;
      done_n  = '0;
    end else begin
      case (state)
        WARMUP: begin
          if (sample_counter >= 64'd3) begin
            state_n = rearm ? ARMED : HOLDOFF;
            hold_n  = '0;
          end
        end
        ARMED: begin
          if (over) begin
            trig_n  = (triggers_count == 16'hFFFF) ? triggers_count : triggers_count + 16'd1;
            first_n = s3_stamp;
            if (record_len == 32'd0) begin
              state_n = HOLDOFF;
              hold_n  = holdoff_len;
            end else if (record_len == 32'd1) begin
              vld_n   = 1'b1;
              last_n  = 1'b1;
              done_n  = records_done + 32'd1;
              state_n = HOLDOFF;
              hold_n  = holdoff_len;
            end else begin
              vld_n   = 1'b1;
              rem_n   = record_len - 32'd1;
              state_n = CAPTURE;
            end
          end
        end
        CAPTURE: begin
          vld_n = 1'b1;
          if (rem == 32'd1) begin
            last_n  = 1'b1;
            done_n  = records_done + 32'd1;
            state_n = HOLDOFF;
            hold_n  = holdoff_len;
          end else begin
            rem_n = rem - 32'd1;
          end
        end
        HOLDOFF: begin
          if (hold <= 32'd1) begin
            if (rearm) state_n = ARMED;
          end else begin
            hold_n = hold - 32'd1;
          end
        end
        default: state_n = WARMUP;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= WARMUP;
      rem            <= '0;
      hold           <= '0;
      triggers_count <= '0;
      first_trigged  <= '0;
      records_done   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tdata   <= '0;
    end else begin
      state          <= state_n;
      rem            <= rem_n;
      hold           <= hold_n;
      triggers_count <= trig_n;
      first_trigged  <= first_n;
      records_done   <= done_n;
      m_axis_tvalid  <= vld_n;
      m_axis_tlast   <= last_n;
      m_axis_tdata   <= dly_word;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dropped_count <= '0;
      max_sum_out   <= '0;
    end else begin
      if (reset_trigger)
        dropped_count <= '0;
      else if (m_axis_tvalid && !m_axis_tready && dropped_count != 32'hFFFF_FFFF)
        dropped_count <= dropped_count + 32'd1;
      if (reset_max_sum)
        max_sum_out <= '0;
      else if (state != WARMUP && s3_sum > max_sum_out)
        max_sum_out <= s3_sum;
    end
  end

endmodule

// File: tb/tb_adc_trig_capture.sv
// Directed bench for adc_trig_capture (N_CH=2, 14-bit, PRE_DEPTH=16); outputs sampled 1 time unit after each rising edge.
module tb_adc_trig_capture;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [31:0]  adc_dat;
  logic [15:0]  trigger_level, hysteresis;
  logic [31:0]  record_len, holdoff_len;
  logic         reset_trigger, reset_max_sum, m_axis_tready;
  logic         m_axis_tvalid, m_axis_tlast;
  logic [111:0] m_axis_tdata;
  logic [15:0]  max_sum_out, triggers_count;
  logic [63:0]  first_trigged, cur_sample;
  logic [31:0]  records_done, dropped_count;
  logic [1:0]   state_out;

  always #5 aclk = ~aclk;

  adc_trig_capture dut (
    .aclk(aclk), .aresetn(aresetn), .adc_dat(adc_dat),
    .trigger_level(trigger_level), .hysteresis(hysteresis),
    .record_len(record_len), .holdoff_len(holdoff_len),
    .reset_trigger(reset_trigger), .reset_max_sum(reset_max_sum),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
    .max_sum_out(max_sum_out), .triggers_count(triggers_count),
    .first_trigged(first_trigged), .records_done(records_done),
    .dropped_count(dropped_count), .state_out(state_out), .cur_sample(cur_sample)
  );

  int           n_cmp = 0, n_bad = 0;
  longint       cnt = 0;
  int           nw, nlast, gaps;
  logic [63:0]  last_st, first_st, tlast_st, probe_st, trig_st;
  logic [111:0] probe, first_word;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [63:0] st;
    @(posedge aclk);
    #1;
    cnt++;
    if (m_axis_tvalid === 1'b1) begin
      st = m_axis_tdata[111:48];
      if (nw == 0) begin
        first_st   = st;
        first_word = m_axis_tdata;
      end else if (st != last_st + 64'd1) gaps++;
      last_st = st;
      if (st == probe_st) probe = m_axis_tdata;
      nw++;
      if (m_axis_tlast === 1'b1) begin
        nlast++;
        tlast_st = st;
      end
    end
  endtask

  task automatic step_to(input longint t);
    while (cnt < t) step();
  endtask

  task automatic clr_mon();
    nw = 0; nlast = 0; gaps = 0;
    first_st = '0; last_st = '0; tlast_st = '0;
    probe = '0; first_word = '0;
  endtask

  // Sum s split as ch0=+s/2, ch1=-(s-s/2); 14-bit codes sit in bits [15:2].
  task automatic set_sum(input int s);
    int a, b;
    logic [15:0] wa, wb;
    a = s / 2;
    b = s - a;
    wa = 16'(a * 4);
    wb = 16'(-(b * 4));
    adc_dat = {wb, wa};
  endtask

  initial begin
    adc_dat = '0; trigger_level = 16'd1000; hysteresis = 16'd100;
    record_len = 32'd64; holdoff_len = 32'd10;
    reset_trigger = 1'b0; reset_max_sum = 1'b0; m_axis_tready = 1'b1;
    probe_st = 64'hFFFF_FFFF_FFFF_FFFF;
    clr_mon();
    #12;
    chk("rst_state", 64'(state_out), 64'd0);
    chk("rst_cur_sample", cur_sample, 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_max", 64'(max_sum_out), 64'd0);
    chk("rst_trig", 64'(triggers_count), 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    cnt = 0;

    step_to(3);
    chk("warmup_at_3", 64'(state_out), 64'd0);
    step();
    chk("armed_at_4", 64'(state_out), 64'd1);
    step_to(10);
    chk("cur_sample", cur_sample, 64'(cnt));

    // Sum equal to the level must not trigger.
    step_to(50);
    set_sum(1000);
    step_to(120);
    chk("eq_level_no_trig", 64'(triggers_count), 64'd0);
    chk("eq_level_state", 64'(state_out), 64'd1);
    chk("max_1000", 64'(max_sum_out), 64'd1000);
    step_to(150);
    set_sum(0);

    // First record: step to 1500 stamped 200.
    probe_st = 64'd200;
    step_to(198);
    set_sum(1500);
    step_to(300);
    chk("r1_words", 64'(nw), 64'd64);
    chk("r1_first_stamp", first_st, 64'd184);
    chk("r1_last_stamp", last_st, 64'd247);
    chk("r1_tlast_stamp", tlast_st, 64'd247);
    chk("r1_tlast_count", 64'(nlast), 64'd1);
    chk("r1_gaps", 64'(gaps), 64'd0);
    chk("r1_pre_sum", 64'(first_word[47:32]), 64'd0);
    chk("r1_probe_sum", 64'(probe[47:32]), 64'd1500);
    chk("r1_probe_ch1", 64'(probe[31:16]), 64'h0000_0000_0000_FD12);
    chk("r1_probe_ch0", 64'(probe[15:0]), 64'h0000_0000_0000_02EE);
    chk("r1_trig", 64'(triggers_count), 64'd1);
    chk("r1_done", 64'(records_done), 64'd1);
    chk("r1_first_trigged", first_trigged, 64'd200);
    chk("r1_holdoff_state", 64'(state_out), 64'd3);

    // Oscillate across the level while in holdoff: no retrigger.
    for (int i = 0; i < 40; i++) begin
      set_sum((i % 2) ? 1050 : 950);
      step();
    end
    chk("osc_no_trig", 64'(triggers_count), 64'd1);
    chk("osc_state", 64'(state_out), 64'd3);
    set_sum(900);
    step_to(346);
    chk("rearm_at_disarm", 64'(state_out), 64'd1);
    clr_mon();
    probe_st = 64'd352;
    step_to(350);
    set_sum(1200);
    step_to(370);
    m_axis_tready = 1'b0;
    repeat (5) step();
    m_axis_tready = 1'b1;
    step_to(450);
    chk("r2_words", 64'(nw), 64'd64);
    chk("r2_first_stamp", first_st, 64'd336);
    chk("r2_tlast_stamp", tlast_st, 64'd399);
    chk("r2_tlast_count", 64'(nlast), 64'd1);
    chk("r2_gaps", 64'(gaps), 64'd0);
    chk("r2_trig", 64'(triggers_count), 64'd2);
    chk("r2_done", 64'(records_done), 64'd2);
    chk("r2_dropped", 64'(dropped_count), 64'd5);
    chk("r2_first_trigged", first_trigged, 64'd352);
    chk("r2_probe_sum", 64'(probe[47:32]), 64'd1200);

    // Most-negative code on ch0.
    adc_dat = {16'h0000, 16'h8000};
    step_to(456);
    chk("max_neg_full", 64'(max_sum_out), 64'd8192);
    reset_max_sum = 1'b1;
    step();
    chk("max_cleared", 64'(max_sum_out), 64'd0);
    reset_max_sum = 1'b0;
    step();
    chk("max_reload", 64'(max_sum_out), 64'd8192);

    // reset_trigger: first as a clean rearm, then mid-capture.
    set_sum(0);
    repeat (6) step();
    reset_trigger = 1'b1;
    step();
    reset_trigger = 1'b0;
    chk("rt_state", 64'(state_out), 64'd1);
    chk("rt_trig", 64'(triggers_count), 64'd0);
    chk("rt_done", 64'(records_done), 64'd0);
    chk("rt_dropped", 64'(dropped_count), 64'd0);
    chk("rt_first", first_trigged, 64'd0);
    clr_mon();
    set_sum(1500);
    repeat (8) step();
    set_sum(0);
    repeat (4) step();
    reset_trigger = 1'b1;
    step();
    reset_trigger = 1'b0;
    chk("abort_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("abort_state", 64'(state_out), 64'd1);
    chk("abort_trig", 64'(triggers_count), 64'd0);
    chk("abort_done", 64'(records_done), 64'd0);
    repeat (10) step();
    chk("abort_words", 64'(nw), 64'd9);
    chk("abort_no_tlast", 64'(nlast), 64'd0);

    // Zero-length record.
    record_len = 32'd0;
    clr_mon();
    trig_st = 64'(cnt) + 64'd2;
    set_sum(1500);
    repeat (8) step();
    chk("rl0_trig", 64'(triggers_count), 64'd1);
    chk("rl0_first", first_trigged, trig_st);
    chk("rl0_words", 64'(nw), 64'd0);
    chk("rl0_done", 64'(records_done), 64'd0);
    chk("rl0_state", 64'(state_out), 64'd3);

    // Asynchronous reset mid-record.
    record_len = 32'd64;
    set_sum(0);
    repeat (16) step();
    chk("pre_ar_state", 64'(state_out), 64'd1);
    clr_mon();
    set_sum(1500);
    repeat (8) step();
    chk("pre_ar_tvalid", 64'(m_axis_tvalid), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("ar_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("ar_tlast", 64'(m_axis_tlast), 64'd0);
    chk("ar_state", 64'(state_out), 64'd0);
    chk("ar_cur_sample", cur_sample, 64'd0);
    chk("ar_no_tlast_seen", 64'(nlast), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_trig_capture.md
ADC_TRIG_CAPTURE -- requirements
Module: adc_trig_capture

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of ADC channels (1..4).
REQ-002 SHALL have parameter ADC_DATA_WIDTH, default 14, significant MSBs per 16-bit ADC word (10..15).
REQ-003 SHALL have parameter PRE_DEPTH, default 16, pre-trigger samples (power of 2, 2..1024).
REQ-004 SHALL have ports aclk in 1 (clock) and aresetn in 1 (reset); reset aresetn is asynchronous, active-low; clock aclk.
REQ-005 SHALL have adc_dat in N_CH*16, channel k in bits [16k+15:16k], two's complement, MSB-aligned.
REQ-006 SHALL have trigger_level in 16, hysteresis in 16, record_len in 32, holdoff_len in 32.
REQ-007 SHALL have reset_trigger in 1 and reset_max_sum in 1.
REQ-008 SHALL have m_axis_tvalid out 1, m_axis_tready in 1, m_axis_tlast out 1, m_axis_tdata out 80+16*N_CH.
REQ-009 SHALL have outputs: max_sum_out 16, triggers_count 16, first_trigged 64, records_done 32, dropped_count 32, state_out 2, cur_sample 64.

Function
REQ-010 SHALL run a free 64-bit sample_counter incrementing every aclk, wrapping at 2^64; cur_sample = sample_counter.
REQ-011 SHALL pipeline: S1 register adc_dat[16k+15:16k+16-ADC_DATA_WIDTH]; S2 absolute value per channel; S3 sum of all abs values, zero-extended to 16 bits.
REQ-012 SHALL make abs of the most-negative code equal 2^(ADC_DATA_WIDTH-1), not wrap to negative.
REQ-013 SHALL tag each S3 sum with sample_counter value at the cycle it is registered (stamp).
REQ-014 SHALL pass S1 raw channel words, sign-extended to 16 bits, through S2/S3 aligned with their sum.
REQ-015 SHALL form word = {stamp[63:0], sum[15:0], ch[N_CH-1]..ch[0] (16 each), 16'hA1B2}.
REQ-016 SHALL delay each word by exactly PRE_DEPTH cycles (circular buffer) before m_axis_tdata.
REQ-017 SHALL use states WARMUP(0), ARMED(1), CAPTURE(2), HOLDOFF(3), reported on state_out.
REQ-018 WARMUP SHALL last until sample_counter reaches 3, then go to ARMED; no triggers or max updates in WARMUP.
REQ-019 ARMED: sum > trigger_level SHALL go to CAPTURE, set first_trigged=stamp, increment triggers_count (saturate at 16'hFFFF).
REQ-020 ARMED entry SHALL require sum <= disarm, disarm = trigger_level - hysteresis saturated at 0; otherwise wait in HOLDOFF.
REQ-021 CAPTURE SHALL present record_len consecutive delayed words starting with the word whose stamp = first_trigged - PRE_DEPTH.
REQ-022 m_axis_tlast SHALL be 1 only on the final word of a record; record_len=1 gives a single word with tlast=1.
REQ-023 record_len=0 SHALL count the trigger, emit no words, not increment records_done, go straight to HOLDOFF.
REQ-024 After the last word SHALL increment records_done and enter HOLDOFF for holdoff_len cycles (0 = one cycle).
REQ-025 HOLDOFF SHALL go to ARMED when its count expires and sum <= disarm.
REQ-026 Samples cannot stall: a word with tvalid=1 and tready=0 SHALL be discarded, dropped_count++ (saturating), record still advances.
REQ-027 tvalid SHALL be asserted only for record words; tdata/tlast are don't-care when tvalid=0.
REQ-028 max_sum_out SHALL track the maximum sum after WARMUP; reset_max_sum=1 clears it to 0 with priority over update.
REQ-029 reset_trigger=1 SHALL have priority over all state logic: state to ARMED; clear triggers_count, first_trigged, records_done, dropped_count; tvalid=0 next cycle, aborting any record without tlast.
REQ-030 Pre-trigger words stamped before WARMUP exit SHALL be emitted with sum and channels forced to 0.

Reset
REQ-031 On aresetn=0 SHALL set all outputs, counters and pipeline registers to 0 and state to WARMUP, asynchronously.
REQ-032 Reset mid-record SHALL drop tvalid immediately, with no tlast emitted.

Verification
REQ-033 N_CH=2, level 1000, hyst 100, PRE_DEPTH 16, record_len 64, sum step 0->1500 at stamp 200 -> 64 words, stamps 184..247, tlast on 247, triggers_count=1, records_done=1.
REQ-034 Sum oscillating 950..1050 after trigger, holdoff 10 -> no second trigger until sum <= 900, then 1200 -> triggers_count=2.
REQ-035 tready=0 for 5 cycles mid-record -> dropped_count=5, tlast still at stamp first_trigged-16+record_len-1.
REQ-036 Channel a = 16'h8000, b = 0, ADC_DATA_WIDTH=14 -> sum=8192, max_sum_out=8192.
REQ-037 reset_trigger pulse during CAPTURE -> tvalid 0 next cycle, no tlast, state_out=1, counters 0.
REQ-038 record_len=0 trigger -> triggers_count=1, no tvalid, records_done=0, state_out=3.
